// File: rtl/sync_fifo_stream_reader.sv
// sync_fifo_stream_reader
// Read-side master for sync_fifo: pulls words through the FIFO read port and
// presents them on a valid/ready stream. A 2-entry output buffer hides the
// FIFO's one-cycle read latency so the stream can sustain one word per clock.

module sync_fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  words_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t              occ;
    occ_t              occ_next;
    logic              inflight;
    logic              pop;
    logic [1:0]        occ_after_pop;
    logic [2:0]        occ_sum;
    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;

    assign m_valid = (occ != EMPTY);
    assign m_data  = slot0;
    assign busy    = m_valid | inflight;

    // Next occupancy and read gate: only read when the arriving word is sure to find a free slot
    always_comb begin
        pop           = 1'b0;
        occ_after_pop = 2'd0;
        occ_sum       = 3'd0;
        occ_next      = occ;
        fifo_rd_en    = 1'b0;

        pop           = m_valid & m_ready;
        occ_after_pop = 2'(occ) - {1'b0, pop};
        occ_sum       = {1'b0, occ_after_pop} + {2'b00, inflight};
        occ_next      = occ_t'(occ_sum[1:0]);
        fifo_rd_en    = rstn & en & ~fifo_empty & (occ_sum < 3'd2);
    end

    // Occupancy state and in-flight flag; reset drops any read still in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_rd_en;
        end
    end

    // Buffer slots: pop shifts slot1 to the head, arriving word lands at the tail
    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop && (occ == TWO)) begin
                slot0 <= slot1;
            end
            if (inflight) begin
                if (occ_after_pop == 2'd0) begin
                    slot0 <= fifo_rdata;
                end else begin
                    slot1 <= fifo_rdata;
                end
            end
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!rstn) begin
            words_out <= '0;
        end else if (pop) begin
            words_out <= words_out + CNT_W'(1);
        end
    end

    // The read gate must never let the buffer exceed two entries
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (occ_sum <= 3'd2);
        end
    end

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// tb_sync_fifo_stream_reader
// Directed bench for sync_fifo_stream_reader. A small FIFO model and an
// expected-word queue live in the single stimulus process; inputs change
// 2 time units after each rising edge and outputs are checked on the falling edge.

module tb_sync_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd_en;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [3:0] words_out;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    int         rd_en_count = 0;
    logic       rd_pending = 1'b0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    sync_fifo_stream_reader #(
        .DATA_W(8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .words_out (words_out),
        .busy      (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_push(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic fifo_clear();
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
    endtask

    // Rising edge: the FIFO model serves a read accepted in the previous cycle
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rd_pending) begin
            fifo_rdata = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
    endtask

    // Falling edge: watch the read strobe and score every stream transfer
    task automatic sample();
        logic [7:0] exp_word;
        @(negedge clk);
        if (fifo_rd_en === 1'b1) begin
            rd_en_count++;
            check("no_underflow", {31'b0, fifo_empty}, 32'd0);
        end
        rd_pending = (fifo_rd_en === 1'b1) && !fifo_empty;
        if (rstn === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL spurious_transfer: observed=%0h required=no transfer", m_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("stream_order", {24'b0, m_data}, {24'b0, exp_word});
            end
        end
    endtask

    task automatic reset_dut();
        cyc();
        rstn = 1'b0;
        fifo_clear();
        sample();
        check("reset_rd_gate", {31'b0, fifo_rd_en}, 32'd0);
        cyc();
        rstn = 1'b1;
        sample();
        check("reset_m_valid", {31'b0, m_valid}, 32'd0);
        check("reset_words_out", {28'b0, words_out}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        int first;
        int last;
        int n;

        rstn       = 1'b0;
        en         = 1'b1;
        m_ready    = 1'b1;
        fifo_rdata = 8'h00;
        fifo_empty = 1'b1;

        // Reset held with a word waiting in the FIFO
        fifo_push(8'hA5);
        repeat (3) begin
            cyc();
            sample();
            check("t1_rd_en", {31'b0, fifo_rd_en}, 32'd0);
            check("t1_m_valid", {31'b0, m_valid}, 32'd0);
            check("t1_words_out", {28'b0, words_out}, 32'd0);
            check("t1_busy", {31'b0, busy}, 32'd0);
        end
        check("t1_fifo_untouched", 32'(fifo_q.size()), 32'd1);

        // Two words, consumer always ready
        reset_dut();
        cyc();
        fifo_push(8'hA5);
        fifo_push(8'h5A);
        base = rd_en_count;
        sample();
        check("t2_rd_en_c0", {31'b0, fifo_rd_en}, 32'd1);
        cyc();
        sample();
        check("t2_rd_en_c1", {31'b0, fifo_rd_en}, 32'd1);
        check("t2_m_valid_c1", {31'b0, m_valid}, 32'd0);
        check("t2_busy_c1", {31'b0, busy}, 32'd1);
        cyc();
        sample();
        check("t2_m_valid_c2", {31'b0, m_valid}, 32'd1);
        check("t2_m_data_c2", {24'b0, m_data}, 32'hA5);
        check("t2_rd_en_c2", {31'b0, fifo_rd_en}, 32'd0);
        cyc();
        sample();
        check("t2_m_valid_c3", {31'b0, m_valid}, 32'd1);
        check("t2_m_data_c3", {24'b0, m_data}, 32'h5A);
        check("t2_words_c3", {28'b0, words_out}, 32'd1);
        cyc();
        sample();
        check("t2_m_valid_c4", {31'b0, m_valid}, 32'd0);
        check("t2_busy_c4", {31'b0, busy}, 32'd0);
        check("t2_words_c4", {28'b0, words_out}, 32'd2);
        check("t2_rd_pulses", 32'(rd_en_count - base), 32'd2);

        // Consumer stalled: buffer fills to two then holds the head
        reset_dut();
        cyc();
        m_ready = 1'b0;
        fifo_push(8'hFF);
        fifo_push(8'h00);
        fifo_push(8'h11);
        fifo_push(8'h22);
        base = rd_en_count;
        sample();
        cyc();
        sample();
        for (int i = 0; i < 4; i++) begin
            cyc();
            sample();
            check("t3_hold_valid", {31'b0, m_valid}, 32'd1);
            check("t3_hold_data", {24'b0, m_data}, 32'hFF);
            check("t3_hold_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        end
        check("t3_rd_pulses", 32'(rd_en_count - base), 32'd2);
        check("t3_fifo_left", 32'(fifo_q.size()), 32'd2);
        cyc();
        m_ready = 1'b1;
        sample();
        check("t3_data_0", {24'b0, m_data}, 32'hFF);
        check("t3_rd_en_release", {31'b0, fifo_rd_en}, 32'd1);
        cyc();
        sample();
        check("t3_data_1", {24'b0, m_data}, 32'h00);
        cyc();
        sample();
        check("t3_data_2", {24'b0, m_data}, 32'h11);
        cyc();
        sample();
        check("t3_data_3", {24'b0, m_data}, 32'h22);
        check("t3_valid_3", {31'b0, m_valid}, 32'd1);
        cyc();
        sample();
        check("t3_drained", {31'b0, m_valid}, 32'd0);
        check("t3_words", {28'b0, words_out}, 32'd4);

        // Empty FIFO: no reads at all
        reset_dut();
        base = rd_en_count;
        for (int i = 0; i < 20; i++) begin
            cyc();
            sample();
            check("t4_rd_en", {31'b0, fifo_rd_en}, 32'd0);
            check("t4_m_valid", {31'b0, m_valid}, 32'd0);
        end
        check("t4_rd_pulses", 32'(rd_en_count - base), 32'd0);

        // Enable dropped right after one read
        reset_dut();
        cyc();
        fifo_push(8'h3C);
        fifo_push(8'hC3);
        fifo_push(8'h77);
        base = rd_en_count;
        sample();
        check("t5_rd_en_c0", {31'b0, fifo_rd_en}, 32'd1);
        cyc();
        en = 1'b0;
        sample();
        check("t5_rd_en_c1", {31'b0, fifo_rd_en}, 32'd0);
        check("t5_busy_c1", {31'b0, busy}, 32'd1);
        cyc();
        sample();
        check("t5_m_valid_c2", {31'b0, m_valid}, 32'd1);
        check("t5_m_data_c2", {24'b0, m_data}, 32'h3C);
        cyc();
        sample();
        check("t5_m_valid_c3", {31'b0, m_valid}, 32'd0);
        check("t5_words_c3", {28'b0, words_out}, 32'd1);
        repeat (3) begin
            cyc();
            sample();
        end
        check("t5_rd_pulses", 32'(rd_en_count - base), 32'd1);
        check("t5_fifo_left", 32'(fifo_q.size()), 32'd2);

        // Seventeen back-to-back transfers wrap the 4-bit counter
        reset_dut();
        en = 1'b1;
        cyc();
        for (int i = 0; i < 17; i++) begin
            fifo_push(8'(8'h40 + i));
        end
        sample();
        first = -1;
        last  = -1;
        n     = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            sample();
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (first < 0) begin
                    first = i;
                end
                last = i;
                n++;
            end
            if (n == 17 && busy === 1'b0) begin
                break;
            end
        end
        check("t6_transfers", 32'(n), 32'd17);
        check("t6_no_bubbles", 32'(last - first + 1), 32'd17);
        check("t6_idle", {31'b0, busy}, 32'd0);
        check("t6_words_wrap", {28'b0, words_out}, 32'd1);

        // Reset while the buffer is full: buffered words must vanish
        cyc();
        m_ready = 1'b0;
        fifo_push(8'h91);
        fifo_push(8'h92);
        fifo_push(8'h93);
        fifo_push(8'h94);
        sample();
        repeat (2) begin
            cyc();
            sample();
        end
        cyc();
        sample();
        check("t6_full_valid", {31'b0, m_valid}, 32'd1);
        check("t6_full_data", {24'b0, m_data}, 32'h91);
        check("t6_full_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        cyc();
        rstn = 1'b0;
        fifo_clear();
        sample();
        check("t6_rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        cyc();
        rstn = 1'b1;
        m_ready = 1'b1;
        sample();
        check("t6_rst_valid", {31'b0, m_valid}, 32'd0);
        check("t6_rst_words", {28'b0, words_out}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        repeat (5) begin
            cyc();
            sample();
            check("t6_post_rst_valid", {31'b0, m_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
